// File: rtl/result_bcd_display.sv
// result_bcd_display: converts the accumulator result to three BCD digits
// with an iterative double-dabble converter. It also drives four active-low
// 7-segment digits (sign, hundreds, tens, ones) with leading-zero blanking.
module result_bcd_display #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SIGNED_MODE,
    input  logic [WIDTH-1:0] VALUE,
    input  logic             OVERFLOW_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [3:0]       BCD_HUN,
    output logic [3:0]       BCD_TEN,
    output logic [3:0]       BCD_ONE,
    output logic             NEG,
    output logic             ERR,
    output logic [6:0]       HEX_SIGN,
    output logic [6:0]       HEX_HUN,
    output logic [6:0]       HEX_TEN,
    output logic [6:0]       HEX_ONE
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t             state, state_next;
    logic               load, shift_en, latch_en;
    logic [WIDTH+11:0]  shreg;
    logic [2:0]         cnt;
    logic               neg_pend, err_pend;

    logic signed [WIDTH:0] val_ext;
    logic                  neg_now;
    logic [WIDTH-1:0]      mag;
    logic [3:0]            hun_d, ten_d, one_d;
    logic [6:0]            seg_sign, seg_hun, seg_ten, seg_one;

    // Add 3 to a BCD nibble that would overflow past 9 after doubling.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // One double-dabble iteration: adjust the three BCD nibbles, then shift left.
    function automatic logic [WIDTH+11:0] dabble_step(input logic [WIDTH+11:0] s);
        logic [WIDTH+11:0] t;
        t = s;
        t[WIDTH+3:WIDTH]    = add3(s[WIDTH+3:WIDTH]);
        t[WIDTH+7:WIDTH+4]  = add3(s[WIDTH+7:WIDTH+4]);
        t[WIDTH+11:WIDTH+8] = add3(s[WIDTH+11:WIDTH+8]);
        return {t[WIDTH+10:0], 1'b0};
    endfunction

    // Active-low segment pattern for a decimal digit, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Magnitude of the incoming value; 8'h80 in signed mode becomes 128.
    always_comb begin
        val_ext = SIGNED_MODE ? {VALUE[WIDTH-1], VALUE} : {1'b0, VALUE};
        neg_now = val_ext[WIDTH];
        mag     = neg_now ? WIDTH'(-val_ext) : val_ext[WIDTH-1:0];
    end

    // Digit extraction and display encoding with leading-zero blanking.
    always_comb begin
        hun_d    = shreg[WIDTH+11:WIDTH+8];
        ten_d    = shreg[WIDTH+7:WIDTH+4];
        one_d    = shreg[WIDTH+3:WIDTH];
        seg_hun  = (hun_d == 4'd0) ? SEG_BLANK : seg7(hun_d);
        seg_ten  = (hun_d == 4'd0 && ten_d == 4'd0) ? SEG_BLANK : seg7(ten_d);
        seg_one  = seg7(one_d);
        seg_sign = err_pend ? SEG_E : (neg_pend ? SEG_MINUS : SEG_BLANK);
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == 3'd7) state_next = LATCH;
            end
            LATCH: begin
                latch_en   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath: capture on accept, shift-add-3 while converting.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shreg    <= '0;
            cnt      <= '0;
            neg_pend <= 1'b0;
            err_pend <= 1'b0;
        end else if (load) begin
            shreg    <= {12'b0, mag};
            cnt      <= '0;
            neg_pend <= neg_now;
            err_pend <= OVERFLOW_IN;
        end else if (shift_en) begin
            shreg <= dabble_step(shreg);
            cnt   <= cnt + 3'd1;
        end
    end

    // Handshake flags and output registers, updated only when a result latches.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            NEG      <= 1'b0;
            ERR      <= 1'b0;
            BCD_HUN  <= '0;
            BCD_TEN  <= '0;
            BCD_ONE  <= '0;
            HEX_SIGN <= SEG_BLANK;
            HEX_HUN  <= SEG_BLANK;
            HEX_TEN  <= SEG_BLANK;
            HEX_ONE  <= SEG_ZERO;
        end else begin
            BUSY <= (state_next != IDLE);
            DONE <= latch_en;
            if (latch_en) begin
                NEG      <= neg_pend;
                ERR      <= err_pend;
                BCD_HUN  <= hun_d;
                BCD_TEN  <= ten_d;
                BCD_ONE  <= one_d;
                HEX_SIGN <= seg_sign;
                HEX_HUN  <= seg_hun;
                HEX_TEN  <= seg_ten;
                HEX_ONE  <= seg_one;
            end
        end
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed testbench for result_bcd_display.
module tb_result_bcd_display;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic       SIGNED_MODE;
    logic [7:0] VALUE;
    logic       OVERFLOW_IN;
    logic       BUSY, DONE, NEG, ERR;
    logic [3:0] BCD_HUN, BCD_TEN, BCD_ONE;
    logic [6:0] HEX_SIGN, HEX_HUN, HEX_TEN, HEX_ONE;

    int checks   = 0;
    int failures = 0;

    result_bcd_display #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SIGNED_MODE(SIGNED_MODE),
        .VALUE(VALUE), .OVERFLOW_IN(OVERFLOW_IN), .BUSY(BUSY), .DONE(DONE),
        .BCD_HUN(BCD_HUN), .BCD_TEN(BCD_TEN), .BCD_ONE(BCD_ONE),
        .NEG(NEG), .ERR(ERR), .HEX_SIGN(HEX_SIGN), .HEX_HUN(HEX_HUN),
        .HEX_TEN(HEX_TEN), .HEX_ONE(HEX_ONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd0);
        check({tag, "_neg_err"}, {30'd0, NEG, ERR}, 32'd0);
        check({tag, "_bcd"}, {20'd0, BCD_HUN, BCD_TEN, BCD_ONE}, 32'h000);
        check({tag, "_hex"}, {4'd0, HEX_SIGN, HEX_HUN, HEX_TEN, HEX_ONE},
              {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    endtask

    // One conversion with a single-cycle START; checks timing and DONE pulse.
    task automatic run_conv(input logic [7:0] v, input logic sm, input logic ov, input string tag);
        int busy_n = 0;
        int lat    = 0;
        bit seen   = 0;
        @(negedge CLK);
        VALUE = v; SIGNED_MODE = sm; OVERFLOW_IN = ov; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0; VALUE = ~v; SIGNED_MODE = ~sm; OVERFLOW_IN = ~ov;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1;
                lat  = i;
                check({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
            end else if (BUSY) begin
                busy_n++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd10);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
    endtask

    task automatic check_result(input string tag, input logic [11:0] bcd, input logic neg,
                                input logic err, input logic [6:0] hs, input logic [6:0] hh,
                                input logic [6:0] ht, input logic [6:0] ho);
        check({tag, "_bcd"}, {20'd0, BCD_HUN, BCD_TEN, BCD_ONE}, {20'd0, bcd});
        check({tag, "_neg"}, 32'(NEG), 32'(neg));
        check({tag, "_err"}, 32'(ERR), 32'(err));
        check({tag, "_hex_sign"}, 32'(HEX_SIGN), 32'(hs));
        check({tag, "_hex_hun"}, 32'(HEX_HUN), 32'(hh));
        check({tag, "_hex_ten"}, 32'(HEX_TEN), 32'(ht));
        check({tag, "_hex_one"}, 32'(HEX_ONE), 32'(ho));
    endtask

    initial begin
        int  lat;
        int  dones;
        bit  seen;

        RESET = 1'b1; START = 1'b0; SIGNED_MODE = 1'b0; VALUE = 8'h00; OVERFLOW_IN = 1'b0;
        #3;
        check_reset_state("por");
        @(negedge CLK);
        RESET = 1'b0;

        // Unsigned full scale
        run_conv(8'hFF, 1'b0, 1'b0, "u255");
        check_result("u255", 12'h255, 1'b0, 1'b0, 7'h7F, 7'b0100100, 7'b0010010, 7'b0010010);
        @(negedge CLK);
        check("u255_done_pulse", 32'(DONE), 32'd0);

        // Signed most negative
        run_conv(8'h80, 1'b1, 1'b0, "s_m128");
        check_result("s_m128", 12'h128, 1'b1, 1'b0, 7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000);

        // Same bits unsigned: NEG forced off
        run_conv(8'h80, 1'b0, 1'b0, "u128");
        check_result("u128", 12'h128, 1'b0, 1'b0, 7'h7F, 7'b1111001, 7'b0100100, 7'b0000000);

        // Signed -10: hundreds blanked
        run_conv(8'hF6, 1'b1, 1'b0, "s_m10");
        check_result("s_m10", 12'h010, 1'b1, 1'b0, 7'b0111111, 7'h7F, 7'b1111001, 7'b1000000);

        // Zero: only ones shown
        run_conv(8'h00, 1'b1, 1'b0, "zero");
        check_result("zero", 12'h000, 1'b0, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'b1000000);

        // Signed +127
        run_conv(8'h7F, 1'b1, 1'b0, "s_127");
        check_result("s_127", 12'h127, 1'b0, 1'b0, 7'h7F, 7'b1111001, 7'b0100100, 7'b1111000);

        // Overflow with START held high through BUSY
        @(negedge CLK);
        VALUE = 8'h05; SIGNED_MODE = 1'b0; OVERFLOW_IN = 1'b1; START = 1'b1;
        @(posedge CLK);
        #1;
        VALUE = 8'h09; OVERFLOW_IN = 1'b0;
        seen = 0; lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) begin seen = 1; lat = i; end
        end
        check("hold_first_latency", 32'(lat), 32'd10);
        check_result("hold_first", 12'h005, 1'b0, 1'b1, 7'b0000110, 7'h7F, 7'h7F, 7'b0010010);
        seen = 0; lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) begin seen = 1; lat = i; end
        end
        START = 1'b0;
        check("hold_restart_period", 32'(lat), 32'd10);
        check_result("hold_second", 12'h009, 1'b0, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'b0010000);

        // Reset after the 4th shift aborts the conversion
        @(negedge CLK);
        VALUE = 8'd77; SIGNED_MODE = 1'b0; OVERFLOW_IN = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        check("abort_hold_bcd", {20'd0, BCD_HUN, BCD_TEN, BCD_ONE}, 32'h009);
        check("abort_busy_before", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        #1;
        check_reset_state("abort");
        @(negedge CLK);
        RESET = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge CLK);
            if (DONE || BUSY) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check_reset_state("abort_after");

        // Fresh conversion after reset release
        run_conv(8'd42, 1'b0, 1'b0, "u42");
        check_result("u42", 12'h042, 1'b0, 1'b0, 7'h7F, 7'h7F, 7'b0011001, 7'b0100100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_bcd_display.md
Name: result_bcd_display

Overview:
- Downstream stage of the 8-bit add/sub accumulator. Consumes the registered RESULT and OVERFLOW and converts the value to decimal with an iterative double-dabble (shift-add-3) converter.
- Interprets the value as unsigned (0..255) or two's complement (-128..127).
- Drives four active-low 7-segment digits (sign, hundreds, tens, ones) with leading-zero blanking.
- START/BUSY/DONE handshake: the accumulator control requests a refresh after each accumulate.

Parameters:
- WIDTH, 8, input value width; only 8 is supported, and the BCD output is fixed at 3 digits.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  conversion request; sampled on the rising edge, honoured only in IDLE
- SIGNED_MODE  in  1  1 = VALUE is two's complement; captured with VALUE
- VALUE  in  WIDTH  accumulator result to convert
- OVERFLOW_IN  in  1  accumulator overflow flag; captured with VALUE
- BUSY  out  1  conversion in progress
- DONE  out  1  one-cycle pulse; outputs updated
- BCD_HUN, BCD_TEN, BCD_ONE  out  4 each  magnitude digits
- NEG  out  1  captured value was negative (signed mode only)
- ERR  out  1  captured OVERFLOW_IN
- HEX_SIGN, HEX_HUN, HEX_TEN, HEX_ONE  out  7 each  segments; bit0=a..bit6=g, active low, blank = 7'h7F

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state IDLE; BUSY=0, DONE=0, NEG=0, ERR=0
  - BCD_* = 0
  - HEX_SIGN, HEX_HUN, HEX_TEN = 7'h7F; HEX_ONE = '0' (7'b1000000)
- Reset mid-conversion aborts the conversion: no DONE, shift state cleared.
- States: IDLE, SHIFT, LATCH.
- IDLE, with START=1 at edge k:
  - Capture NEG = SIGNED_MODE & VALUE[7].
  - Magnitude is 9-bit: -VALUE if NEG, else VALUE. 8'h80 signed gives 128.
  - Capture ERR_pending = OVERFLOW_IN.
  - Load the 20-bit shift register {12'b0, mag[7:0]}; iteration counter = 0; BUSY=1; go to SHIFT.
- SHIFT, edges k+1..k+8:
  - Each edge: every BCD nibble >= 5 gets +3, then shift the whole register left by 1; counter++.
  - After the 8th shift (counter wraps 7 -> 0), go to LATCH.
- LATCH, edge k+9:
  - Register BCD_*, NEG, ERR and all HEX_* outputs.
  - DONE=1 for exactly the cycle following k+9; BUSY=0; go to IDLE.
- Latency: START sampled at edge k -> outputs valid and DONE high after edge k+9 (9 cycles).
- Outputs hold their previous values throughout a conversion.
- START while BUSY=1 (SHIFT or LATCH) is ignored; it is not queued. The earliest accepted START is at edge k+10.
- START held high continuously restarts a conversion every 10 cycles.
- Digit encoding: '0'..'9' standard.
- Blanking:
  - HEX_HUN is blank when hundreds = 0.
  - HEX_TEN is blank when hundreds = 0 and tens = 0.
  - HEX_ONE is always shown.
- HEX_SIGN, in priority order:
  - ERR=1: 'E' (7'b0000110)
  - else NEG=1: '-' (7'b0111111)
  - else blank
- In unsigned mode NEG is forced to 0.
- VALUE, SIGNED_MODE and OVERFLOW_IN are don't-care outside the START-accepted edge.

Test Plan:
- Reset asserted asynchronously mid-cycle -> outputs clear immediately: BUSY=0, DONE=0, HEX_ONE=7'b1000000, other HEX=7'h7F, BCD=0.
- Unsigned, VALUE=8'hFF, START pulse at edge k:
  - BUSY high for 9 cycles.
  - DONE pulses after edge k+9.
  - BCD=2/5/5; HEX_HUN=7'b0100100, HEX_TEN=7'b0010010, HEX_ONE=7'b0010010; HEX_SIGN blank.
- Signed, VALUE=8'h80 -> NEG=1, BCD=1/2/8, HEX_SIGN=7'b0111111.
- Signed, VALUE=8'hF6 (-10) -> BCD=0/1/0, HEX_HUN blank, HEX_TEN='1' (7'b1111001), NEG=1.
- Handshake and overflow:
  - START with OVERFLOW_IN=1, VALUE=8'h05, then START held high with VALUE=8'h09 during BUSY -> first DONE shows ERR=1, HEX_SIGN='E', ones='5'.
  - Second conversion accepted only at edge k+10 -> shows 9.
- RESET pulsed after the 4th shift -> no DONE, outputs at reset values; a new START after release with VALUE=8'd42 gives BCD 0/4/2 after 9 cycles.
